// File: rtl/axi_burst_read_responder.sv
// axi_burst_read_responder
//
// Memory-side responder for instruction-cache line fills. It accepts one read
// address and returns a fixed burst of C_BURST_LEN words from an internal
// synchronous-read memory. S_RREADY can apply backpressure at any time. A
// separate single-word write port loads or patches program memory.
//
// Ports:
//   CLK        clock, rising edge
//   RES_N      asynchronous active-low reset; memory contents survive it
//   S_ARADDR   burst start byte address (low byte-lane bits ignored)
//   S_ARVALID  address valid
//   S_ARREADY  address accepted when high together with S_ARVALID
//   S_RDATA    read beat data
//   S_RVALID   beat valid
//   S_RLAST    final beat of the burst
//   S_RREADY   master accepts the current beat
//   W_EN       memory write strobe
//   W_ADDR     write byte address
//   W_DATA     write data
module axi_burst_read_responder #(
  parameter int C_DATA_WIDTH    = 32,
  parameter int C_ADDRESS_WIDTH = 32,
  parameter int C_MEM_DEPTH     = 1024,
  parameter int C_BURST_LEN     = 4
) (
  input  logic                       CLK,
  input  logic                       RES_N,
  input  logic [C_ADDRESS_WIDTH-1:0] S_ARADDR,
  input  logic                       S_ARVALID,
  output logic                       S_ARREADY,
  output logic [C_DATA_WIDTH-1:0]    S_RDATA,
  output logic                       S_RVALID,
  output logic                       S_RLAST,
  input  logic                       S_RREADY,
  input  logic                       W_EN,
  input  logic [C_ADDRESS_WIDTH-1:0] W_ADDR,
  input  logic [C_DATA_WIDTH-1:0]    W_DATA
);

  localparam int IDX_W      = $clog2(C_MEM_DEPTH);
  localparam int BYTE_SHIFT = $clog2(C_DATA_WIDTH / 8);
  localparam int CNT_W      = (C_BURST_LEN > 1) ? $clog2(C_BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(C_BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_DRAIN
  } state_t;

  state_t                  state;
  logic                    arready;
  logic [IDX_W-1:0]        base_idx;
  logic [CNT_W-1:0]        issue_cnt;
  logic                    issue_done;
  logic [CNT_W-1:0]        ret_cnt;

  logic [C_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];
  logic [C_DATA_WIDTH-1:0] mem_q;
  logic                    rd_valid;

  logic                    skid_valid;
  logic [C_DATA_WIDTH-1:0] skid_data;

  logic                    out_valid;
  logic                    out_last;
  logic [C_DATA_WIDTH-1:0] out_data;

  logic                    ar_fire;
  logic                    out_fire;
  logic                    out_load;
  logic [1:0]              held_after;
  logic                    room;
  logic                    issue_go;
  logic [IDX_W-1:0]        rd_idx;
  logic [IDX_W-1:0]        ar_idx;
  logic [IDX_W-1:0]        w_idx;
  logic [CNT_W-1:0]        ret_after;
  logic                    next_last;
  logic                    unused_addr_bits;

  assign S_ARREADY = arready;
  assign S_RVALID  = out_valid;
  assign S_RLAST   = out_last;
  assign S_RDATA   = out_data;

  // Only the word-index bits of either address matter.
  assign unused_addr_bits = ^{S_ARADDR, W_ADDR};

  assign ar_idx = S_ARADDR[BYTE_SHIFT +: IDX_W];
  assign w_idx  = W_ADDR[BYTE_SHIFT +: IDX_W];
  assign rd_idx = base_idx + IDX_W'(issue_cnt);

  assign ar_fire  = arready && S_ARVALID;
  assign out_fire = out_valid && S_RREADY;
  assign out_load = !out_valid || out_fire;

  // Results still held after this edge (output, skid, in-flight read). A new
  // read may be issued only if at most one remains. Then its result always
  // finds a slot next cycle, even if the master keeps S_RREADY low.
  assign held_after = 2'(out_valid) + 2'(skid_valid) + 2'(rd_valid) - 2'(out_fire);
  assign room       = (held_after <= 2'd1);
  assign issue_go   = (state == ST_BURST) && !issue_done && room;

  // A beat loaded into the output register is last when every earlier beat
  // has been accepted by the time it appears.
  assign ret_after = ret_cnt + CNT_W'(out_fire);
  assign next_last = (ret_after == LAST_CNT);

  // Synchronous-read memory without reset, so contents persist across RES_N.
  // The read samples the array before the write updates it, which gives
  // read-first behaviour when both hit the same word.
  always_ff @(posedge CLK) begin
    if (W_EN) begin
      mem[w_idx] <= W_DATA;
    end
    if (issue_go) begin
      mem_q <= mem[rd_idx];
    end
  end

  // Return pipeline: read result -> (skid) -> output register. The skid entry
  // always has priority for the output so beat order is preserved.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      rd_valid   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
    end else begin
      rd_valid <= issue_go;

      if (out_load) begin
        if (skid_valid) begin
          out_valid <= 1'b1;
          out_data  <= skid_data;
          out_last  <= next_last;
        end else if (rd_valid) begin
          out_valid <= 1'b1;
          out_data  <= mem_q;
          out_last  <= next_last;
        end else begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end

      if (out_load && skid_valid) begin
        skid_valid <= rd_valid;
        if (rd_valid) begin
          skid_data <= mem_q;
        end
      end else if (!out_load && rd_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= mem_q;
      end
    end
  end

  // Burst control FSM with registered S_ARREADY, plus the issue and return
  // counters. The issue counter wraps after the final read, so a separate
  // done flag stops further issuing.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state      <= ST_IDLE;
      arready    <= 1'b0;
      base_idx   <= '0;
      issue_cnt  <= '0;
      issue_done <= 1'b0;
      ret_cnt    <= '0;
    end else begin
      if (ar_fire) begin
        base_idx   <= ar_idx;
        issue_cnt  <= '0;
        issue_done <= 1'b0;
        ret_cnt    <= '0;
      end else begin
        if (issue_go) begin
          issue_cnt <= issue_cnt + CNT_W'(1);
          if (issue_cnt == LAST_CNT) begin
            issue_done <= 1'b1;
          end
        end
        if (out_fire) begin
          ret_cnt <= ret_cnt + CNT_W'(1);
        end
      end

      case (state)
        ST_IDLE: begin
          arready <= 1'b1;
          if (ar_fire) begin
            state   <= ST_BURST;
            arready <= 1'b0;
          end
        end
        ST_BURST: begin
          arready <= 1'b0;
          if (out_fire && out_last) begin
            state   <= ST_DRAIN;
            arready <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (ar_fire) begin
            state   <= ST_BURST;
            arready <= 1'b0;
          end else begin
            state   <= ST_IDLE;
            arready <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          arready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_burst_read_responder.md
Name: axi_burst_read_responder

Overview:
AXI4-style burst read responder. It is the memory side that answers line-fill requests issued by the instruction cache. It accepts one read address, then returns a fixed-length burst of C_BURST_LEN words from an internal synchronous-read word memory, with full RREADY backpressure. A separate single-word write port preloads or patches program memory.

Parameters:
C_DATA_WIDTH, 32, width of one data beat and of one memory word
C_ADDRESS_WIDTH, 32, byte address width
C_MEM_DEPTH, 1024, memory depth in words; must be a power of two
C_BURST_LEN, 4, beats per burst (line width / data width); must be at least 1

Ports:
CLK  in  1  clock, rising edge
RES_N  in  1  asynchronous active-low reset
S_ARADDR  in  C_ADDRESS_WIDTH  burst start byte address
S_ARVALID  in  1  address valid
S_ARREADY  out  1  address accepted when high with S_ARVALID
S_RDATA  out  C_DATA_WIDTH  read beat data
S_RVALID  out  1  beat valid
S_RLAST  out  1  final beat of the burst
S_RREADY  in  1  master accepts the beat
W_EN  in  1  memory write strobe
W_ADDR  in  C_ADDRESS_WIDTH  write byte address
W_DATA  in  C_DATA_WIDTH  write data

Behaviour:
- Reset (asynchronous, RES_N=0):
  - S_ARREADY=0, S_RVALID=0, S_RLAST=0, S_RDATA=0.
  - FSM goes to IDLE; beat counters and skid buffer are cleared.
  - Memory contents are retained.
  - S_ARREADY rises on the first CLK edge after RES_N deasserts.
- Word index = byte address >> log2(C_DATA_WIDTH/8), modulo C_MEM_DEPTH. Low byte bits are ignored.
- FSM states:
  - IDLE: S_ARREADY=1. An AR handshake at edge T latches the word index as base, clears the issue and return counters, drops S_ARREADY and moves to BURST.
  - BURST: S_ARREADY=0; S_ARVALID is ignored. Beat i returns word (base+i) mod C_MEM_DEPTH, so addresses wrap at the top of memory. After the handshake of the beat with S_RLAST, the FSM moves to DRAIN.
  - DRAIN: one cycle; S_ARREADY=1 again. An S_ARVALID seen in DRAIN is accepted exactly as in IDLE.
- Read pipeline:
  - Memory read latency is 1 cycle; the output register adds 1 cycle.
  - The first S_RVALID is asserted at T+2.
  - With S_RREADY held high, there is one beat per cycle and no bubbles. Beat C_BURST_LEN-1 carries S_RLAST.
  - S_ARREADY returns at T+2+C_BURST_LEN.
- Backpressure:
  - While S_RVALID=1 and S_RREADY=0, S_RDATA, S_RVALID and S_RLAST hold stable.
  - One in-flight memory result is captured in a 1-entry skid buffer.
  - Memory reads are issued only if the skid buffer is empty or draining this cycle.
  - When S_RREADY re-asserts, beats resume on consecutive cycles with zero bubbles.
  - No beat is lost or duplicated.
- Counters:
  - The issue counter and return counter are each clog2(C_BURST_LEN) bits wide (at least 1).
  - Issuing stops at C_BURST_LEN reads.
  - S_RLAST is asserted when the return counter equals C_BURST_LEN-1.
- Write port:
  - With W_EN=1, memory[word(W_ADDR)] is written at the edge. This is allowed in any state.
  - A write and a read to the same word in the same cycle returns the OLD data (read-first).
  - A beat whose read is issued after the write returns the new data.
- C_BURST_LEN=1: the single beat carries S_RLAST=1.
- Reset mid-burst: outputs clear at once, with no S_RLAST. After reset the responder is in IDLE and accepts a new address.

Test Plan:
1. Preload words 0x100..0x103 with 0xA0..0xA3 via the write port. AR with S_ARADDR=0x400 at edge T and S_RREADY=1 → S_RDATA = A0, A1, A2, A3 at T+2..T+5; S_RLAST only at T+5; S_ARREADY=1 at T+6.
2. Same burst with S_RREADY low on beats 1 and 2 for 3 cycles each → every stalled beat holds stable. The beat sequence is exactly A0..A3, no duplicates, with zero-bubble resumption.
3. AR to word C_MEM_DEPTH-2 (byte address 0xFF8 at depth 1024) → beats are words 1022, 1023, 0, 1.
4. Toggle S_ARVALID with a different address throughout BURST → it is ignored, with no second burst. A new AR presented in the DRAIN cycle is accepted, and its first beat appears 2 cycles later.
5. During a burst, W_EN writes 0xDEAD to word base+3 in the cycle that word base+3 is being read → beat 3 returns the old value. A repeat burst returns 0xDEAD.
6. Drop RES_N after beat 1 → S_RVALID=0 and S_ARREADY=0 immediately. After release, S_ARREADY=1 within 1 edge, and a new burst returns correct data from retained memory.
